// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 5-stage pipelined CPU. Owns the PC, presents
//   it to instruction memory, and captures the returned word into the IF/ID
//   pipeline register. Sequences program start-up (IDLE -> LOAD -> RUN), honours
//   stall / flush / branch redirect, and parks in DONE once the PC runs past the
//   end of the program image.
//
// Ports
//   clk               in   1   system clock, rising edge
//   rst_n             in   1   synchronous active-low reset
//   start             in   1   begins a run when sampled high in IDLE
//   stall             in   1   hold PC and IF/ID
//   flush             in   1   load a bubble into IF/ID
//   branch_taken      in   1   redirect PC to branch_target
//   branch_target     in   32  redirect byte address (low two bits dropped)
//   imem_instruction  in   32  combinational instruction word for imem_address
//   imem_address      out  32  current PC
//   imem_startin      out  1   memory load strobe, high for the LOAD cycle only
//   ifid_pc4          out  32  PC+4 of the captured instruction
//   ifid_instruction  out  32  captured instruction, 0 (nop) for a bubble
//   ifid_valid        out  1   IF/ID holds a real instruction
//   halted            out  1   high while in DONE
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] PC_RESET   = 32'd0,
  parameter logic [31:0] IMEM_BYTES = 32'd60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_instruction,
  output logic [31:0] imem_address,
  output logic        imem_startin,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instruction,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ifid_pc4_reg, ifid_pc4_next;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic        ifid_valid_reg, ifid_valid_next;

  logic [31:0] pc_plus4;
  logic [31:0] branch_pc;

  assign pc_plus4  = pc_reg + 32'd4;                   // wraps modulo 2^32
  assign branch_pc = {branch_target[31:2], 2'b00};     // word-align the redirect

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pc_reg         <= PC_RESET;
      ifid_pc4_reg   <= 32'd0;
      ifid_instr_reg <= 32'd0;
      ifid_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      ifid_pc4_reg   <= ifid_pc4_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_valid_reg <= ifid_valid_next;
    end
  end

  always_comb begin
    // Defaults: stay put, PC holds, IF/ID takes a bubble.
    state_next      = state_reg;
    pc_next         = pc_reg;
    ifid_pc4_next   = 32'd0;
    ifid_instr_next = 32'd0;
    ifid_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        pc_next = PC_RESET;
        if (start) begin
          state_next = LOAD;
        end
      end

      LOAD: begin
        pc_next    = PC_RESET;
        state_next = RUN;
      end

      RUN: begin
        if (branch_taken) begin
          pc_next = branch_pc;
        end else if (stall) begin
          pc_next = pc_reg;
        end else begin
          pc_next = pc_plus4;
        end

        // flush beats stall; a branch alone still captures the fetched word.
        if (!flush) begin
          if (stall) begin
            ifid_pc4_next   = ifid_pc4_reg;
            ifid_instr_next = ifid_instr_reg;
            ifid_valid_next = ifid_valid_reg;
          end else begin
            ifid_pc4_next   = pc_plus4;
            ifid_instr_next = imem_instruction;
            ifid_valid_next = 1'b1;
          end
        end

        // Judged on the PC we are about to present, so a redirect back into
        // the program keeps us running.
        state_next = (pc_next >= IMEM_BYTES) ? DONE : RUN;
      end

      DONE: begin
        // Memory is out of range here; only stall can keep IF/ID contents so
        // instructions already in flight can drain downstream.
        if (!flush && stall) begin
          ifid_pc4_next   = ifid_pc4_reg;
          ifid_instr_next = ifid_instr_reg;
          ifid_valid_next = ifid_valid_reg;
        end
        // A late branch resolved from before the end restarts fetching.
        if (branch_taken) begin
          pc_next    = branch_pc;
          state_next = (branch_pc >= IMEM_BYTES) ? DONE : RUN;
        end
      end

      default: begin
        state_next = IDLE;
        pc_next    = PC_RESET;
      end
    endcase
  end

  assign imem_address     = pc_reg;
  assign imem_startin     = (state_reg == LOAD);
  assign halted           = (state_reg == DONE);
  assign ifid_pc4         = ifid_pc4_reg;
  assign ifid_instruction = ifid_instr_reg;
  assign ifid_valid       = ifid_valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. Each cycle the bench drives inputs,
//   runs its own behavioural model of the fetch stage to predict the outputs
//   after the next rising edge, pushes that prediction onto a scoreboard queue,
//   and pops / compares it against the DUT shortly after the edge. Directed
//   constant checks cover the documented scenarios.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] IMEM_BYTES = 32'd60;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_RUN  = 2;
  localparam int S_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] imem_instruction;
  logic [31:0] imem_address;
  logic        imem_startin;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instruction;
  logic        ifid_valid;
  logic        halted;

  logic [31:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        startin;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t exp_q [$];

  // Reference model state
  int          m_state = S_IDLE;
  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_pc4   = 32'd0;
  logic [31:0] m_instr = 32'd0;
  logic        m_valid = 1'b0;

  always #5 clk = ~clk;

  assign imem_instruction = mem[imem_address[5:2]];

  fetch_stage #(
    .PC_RESET   (32'd0),
    .IMEM_BYTES (IMEM_BYTES)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .stall            (stall),
    .flush            (flush),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_instruction (imem_instruction),
    .imem_address     (imem_address),
    .imem_startin     (imem_startin),
    .ifid_pc4         (ifid_pc4),
    .ifid_instruction (ifid_instruction),
    .ifid_valid       (ifid_valid),
    .halted           (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    logic [31:0] npc;
    logic [31:0] bpc;
    int          nst;
    bpc = {branch_target[31:2], 2'b00};
    npc = m_pc;
    nst = m_state;
    if (!rst_n) begin
      nst = S_IDLE; npc = 32'd0;
      m_pc4 = 0; m_instr = 0; m_valid = 0;
    end else begin
      case (m_state)
        S_IDLE: begin
          npc = 32'd0;
          if (start) nst = S_LOAD;
          m_pc4 = 0; m_instr = 0; m_valid = 0;
        end
        S_LOAD: begin
          npc = 32'd0; nst = S_RUN;
          m_pc4 = 0; m_instr = 0; m_valid = 0;
        end
        S_RUN: begin
          if (branch_taken)  npc = bpc;
          else if (!stall)   npc = m_pc + 32'd4;
          if (flush) begin
            m_pc4 = 0; m_instr = 0; m_valid = 0;
          end else if (!stall) begin
            m_instr = mem[m_pc[5:2]];
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
          end
          nst = (npc >= IMEM_BYTES) ? S_DONE : S_RUN;
        end
        default: begin
          if (flush || !stall) begin
            m_pc4 = 0; m_instr = 0; m_valid = 0;
          end
          if (branch_taken) begin
            npc = bpc;
            nst = (bpc >= IMEM_BYTES) ? S_DONE : S_RUN;
          end
        end
      endcase
    end
    m_pc    = npc;
    m_state = nst;
  endtask

  // One transaction: drive, predict, clock, compare.
  task automatic cycle(input logic r, input logic s, input logic st, input logic fl,
                       input logic br, input logic [31:0] tgt);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst_n = r; start = s; stall = st; flush = fl;
    branch_taken = br; branch_target = tgt;
    #1;
    model_step();
    e.addr    = m_pc;
    e.startin = (m_state == S_LOAD);
    e.pc4     = m_pc4;
    e.instr   = m_instr;
    e.valid   = m_valid;
    e.halted  = (m_state == S_DONE);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    n_cycle++;
    g = exp_q.pop_front();
    $display("cyc %0d rst_n=%b start=%b stall=%b flush=%b br=%b tgt=%h | addr=%h startin=%b pc4=%h instr=%h valid=%b halted=%b",
             n_cycle, r, s, st, fl, br, tgt, imem_address, imem_startin,
             ifid_pc4, ifid_instruction, ifid_valid, halted);
    chk("addr",    imem_address,           g.addr);
    chk("startin", {31'd0, imem_startin},  {31'd0, g.startin});
    chk("pc4",     ifid_pc4,               g.pc4);
    chk("instr",   ifid_instruction,       g.instr);
    chk("valid",   {31'd0, ifid_valid},    {31'd0, g.valid});
    chk("halted",  {31'd0, halted},        {31'd0, g.halted});
  endtask

  task automatic run1();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0] = 32'h2009000A;
    mem[1] = 32'h200A0003;
    mem[2] = 32'h200B0001;
    mem[6] = 32'h112A0008;

    // Reset
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rst_addr",  imem_address, 32'd0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);

    // 1. start pulse, LOAD strobe for one cycle
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("t1_startin_hi", {31'd0, imem_startin}, 32'd1);
    run1();
    chk("t1_startin_lo", {31'd0, imem_startin}, 32'd0);
    run1();
    chk("t1_instr", ifid_instruction, 32'h2009000A);
    chk("t1_pc4",   ifid_pc4, 32'd4);

    // 2/3. run to PC=8, stall two cycles, release
    run1();
    chk("t2_addr", imem_address, 32'd8);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("t3_pc_hold",  imem_address, 32'd8);
    chk("t3_pc4_hold", ifid_pc4, 32'd8);
    run1();
    chk("t3_instr", ifid_instruction, 32'h200B0001);
    chk("t3_pc4",   ifid_pc4, 32'd12);
    run1();

    // 4. branch + flush to misaligned target
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1B);
    chk("t4_valid", {31'd0, ifid_valid}, 32'd0);
    chk("t4_pc",    imem_address, 32'h18);
    run1();
    chk("t4_instr", ifid_instruction, 32'h112A0008);
    chk("t4_pc4",   ifid_pc4, 32'h1C);

    // stall+flush, stall+branch, branch without flush
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0E);
    run1();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h04);

    // 5. free run to the end of the image (bounded)
    n = 0;
    while (m_state != S_DONE && n < 40) begin
      run1();
      n++;
    end
    chk("t5_reached_done", {31'd0, halted}, 32'd1);
    chk("t5_pc", imem_address, 32'd60);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);   // stall drains-hold in DONE
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);   // start ignored in DONE
    chk("t5_drained", {31'd0, ifid_valid}, 32'd0);
    chk("t5_halted",  {31'd0, halted}, 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h18);
    chk("t5_resume_halted", {31'd0, halted}, 32'd0);
    chk("t5_resume_pc",     imem_address, 32'h18);
    run1();
    chk("t5_resume_instr", ifid_instruction, 32'h112A0008);

    // 6. reset mid-run with stall and start high
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("t6_pc4",    ifid_pc4, 32'd0);
    chk("t6_instr",  ifid_instruction, 32'd0);
    chk("t6_startin", {31'd0, imem_startin}, 32'd0);
    run1();
    chk("t6_idle_startin", {31'd0, imem_startin}, 32'd0);
    run1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
